// File: rtl/stream_fifo.sv
// First-word-fall-through stream FIFO: simple dual-port RAM plus a two-entry
// head/skid output stage, exact occupancy count and synchronous flush.
module stream_fifo #(
  parameter int DATA_WIDTH         = 128,
  parameter int DEPTH              = 512,
  parameter int ADDR_WIDTH         = 9,
  parameter int ALMOST_FULL_LEVEL  = DEPTH - 2,
  parameter int ALMOST_EMPTY_LEVEL = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty
);

  localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_C  = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   AF_C    = (ADDR_WIDTH+1)'(ALMOST_FULL_LEVEL);
  localparam logic [ADDR_WIDTH:0]   AE_C    = (ADDR_WIDTH+1)'(ALMOST_EMPTY_LEVEL);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d, unread;
  logic                  inflight_q, head_v_q, head_v_d, skid_v_q, skid_v_d;
  logic [DATA_WIDTH-1:0] rd_data_q, head_q, head_d, skid_q, skid_d;
  logic [1:0]            occ;
  logic                  clr, push, pop, rd_en;

  assign clr      = reset | flush;
  assign s_tready = !clr && (count_q < DEPTH_C);
  assign push     = s_tvalid && s_tready;
  assign pop      = head_v_q && m_tready && !clr;

  // Words in RAM not yet read out; a word pushed this cycle is not counted yet,
  // so a read never targets the address being written.
  assign unread = count_q - {{ADDR_WIDTH{1'b0}}, head_v_q}
                          - {{ADDR_WIDTH{1'b0}}, skid_v_q}
                          - {{ADDR_WIDTH{1'b0}}, inflight_q};
  assign occ    = {1'b0, head_v_q} + {1'b0, skid_v_q} + {1'b0, inflight_q};
  assign rd_en  = !clr && (unread != '0) && ((occ < 2'd2) || (occ == 2'd2 && pop));

  assign wr_ptr_d = !push  ? wr_ptr_q : (wr_ptr_q == LAST_C) ? '0 : wr_ptr_q + 1'b1;
  assign rd_ptr_d = !rd_en ? rd_ptr_q : (rd_ptr_q == LAST_C) ? '0 : rd_ptr_q + 1'b1;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Returning read data goes to head when head is free or leaving, else skid;
  // on a pop with skid occupied, skid advances and the new word lands in skid.
  always_comb begin
    head_v_d = head_v_q;
    skid_v_d = skid_v_q;
    head_d   = head_q;
    skid_d   = skid_q;
    if (pop) begin
      if (skid_v_q) begin
        head_d   = skid_q;
        head_v_d = 1'b1;
        skid_v_d = inflight_q;
        skid_d   = rd_data_q;
      end else begin
        head_v_d = inflight_q;
        head_d   = rd_data_q;
      end
    end else if (inflight_q) begin
      if (!head_v_q) begin
        head_v_d = 1'b1;
        head_d   = rd_data_q;
      end else begin
        skid_v_d = 1'b1;
        skid_d   = rd_data_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= 1'b0;
      head_v_q   <= 1'b0;
      skid_v_q   <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      inflight_q <= rd_en;
      head_v_q   <= head_v_d;
      skid_v_q   <= skid_v_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push)  mem[wr_ptr_q] <= s_tdata;
    if (rd_en) rd_data_q     <= mem[rd_ptr_q];
    head_q <= head_d;
    skid_q <= skid_d;
  end

  assign m_tdata      = head_q;
  assign m_tvalid     = head_v_q;
  assign count        = count_q;
  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);

endmodule

// File: tb/tb_stream_fifo.sv
// Scoreboard bench for stream_fifo: a 512-deep instance (a_*) and a 5-deep
// instance (b_*) share clock and reset; each task checks its own scenario.
module tb_stream_fifo;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        a_flush = 1'b0, a_s_tvalid = 1'b0, a_m_tready = 1'b0;
  logic [31:0] a_s_tdata = '0, a_m_tdata;
  logic        a_s_tready, a_m_tvalid, a_full, a_empty, a_af, a_ae;
  logic [9:0]  a_count;

  logic        b_flush = 1'b0, b_s_tvalid = 1'b0, b_m_tready = 1'b0;
  logic [31:0] b_s_tdata = '0, b_m_tdata;
  logic        b_s_tready, b_m_tvalid, b_full, b_empty, b_af, b_ae;
  logic [3:0]  b_count;

  int checks = 0;
  int failures = 0;
  logic [31:0] qa[$];
  logic [31:0] qb[$];

  stream_fifo #(.DATA_WIDTH(32), .DEPTH(512), .ADDR_WIDTH(9)) u_a (
    .clk(clk), .reset(reset), .flush(a_flush),
    .s_tdata(a_s_tdata), .s_tvalid(a_s_tvalid), .s_tready(a_s_tready),
    .m_tdata(a_m_tdata), .m_tvalid(a_m_tvalid), .m_tready(a_m_tready),
    .count(a_count), .full(a_full), .empty(a_empty),
    .almost_full(a_af), .almost_empty(a_ae));

  stream_fifo #(.DATA_WIDTH(32), .DEPTH(5), .ADDR_WIDTH(3),
                .ALMOST_FULL_LEVEL(3), .ALMOST_EMPTY_LEVEL(1)) u_b (
    .clk(clk), .reset(reset), .flush(b_flush),
    .s_tdata(b_s_tdata), .s_tvalid(b_s_tvalid), .s_tready(b_s_tready),
    .m_tdata(b_m_tdata), .m_tvalid(b_m_tvalid), .m_tready(b_m_tready),
    .count(b_count), .full(b_full), .empty(b_empty),
    .almost_full(b_af), .almost_empty(b_ae));

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic drive_a(input logic v, input logic [31:0] d, input logic r,
                         input logic f, input logic rst);
    @(negedge clk);
    a_s_tvalid = v; a_s_tdata = d; a_m_tready = r; a_flush = f; reset = rst;
    #1;
  endtask

  task automatic drive_b(input logic v, input logic [31:0] d, input logic r);
    @(negedge clk);
    b_s_tvalid = v; b_s_tdata = d; b_m_tready = r;
    #1;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 3; i++) begin
      drive_a(0, 0, 0, 0, 1);
      drive_b(0, 0, 0);
    end
    checks++;
    if (a_s_tready !== 1'b0 || b_s_tready !== 1'b0) begin
      failures++;
      $display("FAIL reset_tready actual=%b/%b required=0/0", a_s_tready, b_s_tready);
    end
    drive_a(0, 0, 0, 0, 0);
    checks++;
    if ({a_s_tready, a_m_tvalid, a_count, a_empty, a_full, a_ae, a_af} !== {1'b1, 1'b0, 10'd0, 4'b1010}) begin
      failures++;
      $display("FAIL reset_a_state actual=rdy%b vld%b cnt%0d e%b f%b ae%b af%b required=rdy1 vld0 cnt0 e1 f0 ae1 af0",
               a_s_tready, a_m_tvalid, a_count, a_empty, a_full, a_ae, a_af);
    end
    checks++;
    if ({b_s_tready, b_m_tvalid, b_count, b_empty, b_full, b_ae, b_af} !== {1'b1, 1'b0, 4'd0, 4'b1010}) begin
      failures++;
      $display("FAIL reset_b_state actual=rdy%b vld%b cnt%0d e%b f%b ae%b af%b required=rdy1 vld0 cnt0 e1 f0 ae1 af0",
               b_s_tready, b_m_tvalid, b_count, b_empty, b_full, b_ae, b_af);
    end
  endtask

  task automatic test_basic;
    logic [31:0] want;
    for (int i = 0; i < 10; i++) begin
      drive_a(i < 5, 32'(i + 1), 1, 0, 0);
      checks++;
      if (a_m_tvalid !== ((i >= 3 && i < 8) ? 1'b1 : 1'b0)) begin
        failures++;
        $display("FAIL basic_latency cycle=%0d actual=%b required=%b", i, a_m_tvalid, (i >= 3 && i < 8));
      end
      if (a_m_tvalid && a_m_tready) begin
        checks++;
        want = (qa.size() != 0) ? qa.pop_front() : 32'hDEAD_BEEF;
        if (a_m_tdata !== want) begin
          failures++;
          $display("FAIL basic_data actual=%h required=%h", a_m_tdata, want);
        end
      end
      if (a_s_tvalid && a_s_tready) qa.push_back(a_s_tdata);
    end
    checks++;
    if (a_count !== 10'd0 || a_empty !== 1'b1 || qa.size() != 0) begin
      failures++;
      $display("FAIL basic_drained actual=cnt%0d e%b left%0d required=cnt0 e1 left0", a_count, a_empty, qa.size());
    end
  endtask

  task automatic test_full;
    int acc = 0;
    int ecnt;
    logic [31:0] want;
    for (int i = 0; i < 7; i++) begin
      drive_b(1, 32'(100 + i), 0);
      ecnt = (i < 5) ? i : 5;
      checks++;
      if (b_count !== 4'(ecnt) || b_af !== (ecnt >= 3) || b_s_tready !== (ecnt < 5)) begin
        failures++;
        $display("FAIL full_fill cycle=%0d actual=cnt%0d af%b rdy%b required=cnt%0d af%b rdy%b",
                 i, b_count, b_af, b_s_tready, ecnt, ecnt >= 3, ecnt < 5);
      end
      if (b_s_tvalid && b_s_tready) begin
        qb.push_back(b_s_tdata);
        acc++;
      end
    end
    drive_b(0, 0, 0);
    checks++;
    if (acc != 5 || b_count !== 4'd5 || b_full !== 1'b1 || b_s_tready !== 1'b0 || b_af !== 1'b1) begin
      failures++;
      $display("FAIL full_state actual=acc%0d cnt%0d f%b rdy%b af%b required=acc5 cnt5 f1 rdy0 af1",
               acc, b_count, b_full, b_s_tready, b_af);
    end
    drive_b(0, 0, 1);
    if (b_m_tvalid && b_m_tready) begin
      checks++;
      want = (qb.size() != 0) ? qb.pop_front() : 32'hDEAD_BEEF;
      if (b_m_tdata !== want) begin
        failures++;
        $display("FAIL full_pop_data actual=%h required=%h", b_m_tdata, want);
      end
    end
    drive_b(0, 0, 0);
    checks++;
    if (b_s_tready !== 1'b1 || b_count !== 4'd4 || b_full !== 1'b0) begin
      failures++;
      $display("FAIL full_after_pop actual=rdy%b cnt%0d f%b required=rdy1 cnt4 f0", b_s_tready, b_count, b_full);
    end
    for (int i = 0; i < 8; i++) begin
      drive_b(0, 0, 1);
      if (b_m_tvalid && b_m_tready) begin
        checks++;
        want = (qb.size() != 0) ? qb.pop_front() : 32'hDEAD_BEEF;
        if (b_m_tdata !== want) begin
          failures++;
          $display("FAIL full_drain_data actual=%h required=%h", b_m_tdata, want);
        end
      end
    end
    checks++;
    if (qb.size() != 0 || b_empty !== 1'b1) begin
      failures++;
      $display("FAIL full_drained actual=left%0d e%b required=left0 e1", qb.size(), b_empty);
    end
  endtask

  task automatic test_back_to_back;
    int pops = 0;
    logic [31:0] want;
    for (int i = 0; i < 46; i++) begin
      drive_b(i < 40, 32'(200 + i), 1);
      if (i < 40) begin
        checks++;
        if (b_count !== 4'((i < 3) ? i : 3) || (i >= 3 && b_m_tvalid !== 1'b1) || b_s_tready !== 1'b1) begin
          failures++;
          $display("FAIL b2b_steady cycle=%0d actual=cnt%0d vld%b rdy%b required=cnt%0d vld%b rdy1",
                   i, b_count, b_m_tvalid, b_s_tready, (i < 3) ? i : 3, i >= 3);
        end
      end
      if (b_m_tvalid && b_m_tready) begin
        checks++;
        pops++;
        want = (qb.size() != 0) ? qb.pop_front() : 32'hDEAD_BEEF;
        if (b_m_tdata !== want) begin
          failures++;
          $display("FAIL b2b_data actual=%h required=%h", b_m_tdata, want);
        end
      end
      if (b_s_tvalid && b_s_tready) qb.push_back(b_s_tdata);
    end
    checks++;
    if (pops != 40 || b_empty !== 1'b1) begin
      failures++;
      $display("FAIL b2b_total actual=pops%0d e%b required=pops40 e1", pops, b_empty);
    end
  endtask

  task automatic test_random;
    int mcnt = 0;
    logic stall;
    logic [31:0] prev, want;
    for (int n = 0; n < 10000; n++) begin
      stall = a_m_tvalid && !a_m_tready;
      prev  = a_m_tdata;
      drive_a(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), 0, 0);
      checks++;
      if (a_count !== 10'(mcnt) || a_empty !== (mcnt == 0) || a_af !== (mcnt >= 510)) begin
        failures++;
        $display("FAIL rand_a_count cycle=%0d actual=cnt%0d e%b af%b required=cnt%0d", n, a_count, a_empty, a_af, mcnt);
      end
      if (stall && (a_m_tvalid !== 1'b1 || a_m_tdata !== prev)) begin
        checks++;
        failures++;
        $display("FAIL rand_a_stall cycle=%0d actual=%b/%h required=1/%h", n, a_m_tvalid, a_m_tdata, prev);
      end else if (stall) checks++;
      if (a_m_tvalid && a_m_tready) begin
        checks++;
        mcnt--;
        want = (qa.size() != 0) ? qa.pop_front() : 32'hDEAD_BEEF;
        if (a_m_tdata !== want) begin
          failures++;
          $display("FAIL rand_a_data cycle=%0d actual=%h required=%h", n, a_m_tdata, want);
        end
      end
      if (a_s_tvalid && a_s_tready) begin
        qa.push_back(a_s_tdata);
        mcnt++;
      end
    end
    drive_a(0, 0, 0, 0, 0);
    mcnt = 0;
    // Slow consumer on the shallow instance keeps it mostly full.
    for (int n = 0; n < 3000; n++) begin
      stall = b_m_tvalid && !b_m_tready;
      prev  = b_m_tdata;
      drive_b(1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 9) < 3));
      checks++;
      if (b_count !== 4'(mcnt) || b_full !== (mcnt == 5) || b_s_tready !== (mcnt < 5) || b_ae !== (mcnt <= 1)) begin
        failures++;
        $display("FAIL rand_b_count cycle=%0d actual=cnt%0d f%b rdy%b ae%b required=cnt%0d", n, b_count, b_full, b_s_tready, b_ae, mcnt);
      end
      if (stall) begin
        checks++;
        if (b_m_tvalid !== 1'b1 || b_m_tdata !== prev) begin
          failures++;
          $display("FAIL rand_b_stall cycle=%0d actual=%b/%h required=1/%h", n, b_m_tvalid, b_m_tdata, prev);
        end
      end
      if (b_m_tvalid && b_m_tready) begin
        checks++;
        mcnt--;
        want = (qb.size() != 0) ? qb.pop_front() : 32'hDEAD_BEEF;
        if (b_m_tdata !== want) begin
          failures++;
          $display("FAIL rand_b_data cycle=%0d actual=%h required=%h", n, b_m_tdata, want);
        end
      end
      if (b_s_tvalid && b_s_tready) begin
        qb.push_back(b_s_tdata);
        mcnt++;
      end
    end
    drive_b(0, 0, 0);
  endtask

  task automatic test_flush;
    int pops = 0;
    logic [31:0] want;
    drive_a(0, 0, 0, 1, 0);
    qa.delete();
    for (int i = 0; i < 6; i++) drive_a(i < 3, 32'(i + 1), 0, 0, 0);
    drive_a(1, 32'h55, 1, 1, 0);
    checks++;
    if (a_s_tready !== 1'b0) begin
      failures++;
      $display("FAIL flush_tready actual=%b required=0", a_s_tready);
    end
    drive_a(0, 0, 1, 0, 0);
    checks++;
    if (a_count !== 10'd0 || a_empty !== 1'b1 || a_m_tvalid !== 1'b0) begin
      failures++;
      $display("FAIL flush_state actual=cnt%0d e%b vld%b required=cnt0 e1 vld0", a_count, a_empty, a_m_tvalid);
    end
    qa.push_back(32'hAA);
    for (int i = 0; i < 6; i++) begin
      drive_a(i == 0, 32'hAA, 1, 0, 0);
      if (a_m_tvalid && a_m_tready) begin
        checks++;
        pops++;
        want = (qa.size() != 0) ? qa.pop_front() : 32'hDEAD_BEEF;
        if (a_m_tdata !== want) begin
          failures++;
          $display("FAIL flush_first_word actual=%h required=%h", a_m_tdata, want);
        end
      end
    end
    checks++;
    if (pops != 1) begin
      failures++;
      $display("FAIL flush_pop_count actual=%0d required=1", pops);
    end
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 12; i++) drive_a(i < 10, 32'(300 + i), 0, 0, 0);
    checks++;
    if (a_count !== 10'd10) begin
      failures++;
      $display("FAIL mid_fill actual=%0d required=10", a_count);
    end
    drive_a(1, 32'h77, 1, 0, 1);
    checks++;
    if (a_s_tready !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_tready actual=%b required=0", a_s_tready);
    end
    qa.delete();
    drive_a(0, 0, 1, 0, 0);
    checks++;
    if ({a_s_tready, a_m_tvalid, a_count, a_empty, a_full, a_ae, a_af} !== {1'b1, 1'b0, 10'd0, 4'b1010}) begin
      failures++;
      $display("FAIL mid_reset_state actual=rdy%b vld%b cnt%0d e%b f%b ae%b af%b required=rdy1 vld0 cnt0 e1 f0 ae1 af0",
               a_s_tready, a_m_tvalid, a_count, a_empty, a_full, a_ae, a_af);
    end
    for (int i = 0; i < 5; i++) begin
      drive_a(0, 0, 1, 0, 0);
      checks++;
      if (a_m_tvalid !== 1'b0) begin
        failures++;
        $display("FAIL mid_stale_word cycle=%0d actual=%b/%h required=0", i, a_m_tvalid, a_m_tdata);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_back_to_back();
    test_random();
    test_flush();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/stream_fifo.md
# stream_fifo

Parametrised first-word-fall-through FIFO with AXI-Stream-style TVALID/TREADY handshakes on both ports, built on a simple dual-port RAM (one write port, one read port) plus a two-entry output prefetch stage. It sustains one write and one read per clock indefinitely, supports non-power-of-two depths, reports exact occupancy with programmable almost-full/almost-empty levels, and provides a synchronous flush. It is the general-purpose buffer between the AXI DMA streams and the AES core datapaths.

## Interface
- DATA_WIDTH, 128, payload width in bits.
- DEPTH, 512, total capacity in words (RAM + output stage), any value ≥ 4.
- ADDR_WIDTH, 9, RAM address width; must satisfy 2^ADDR_WIDTH ≥ DEPTH.
- ALMOST_FULL_LEVEL, DEPTH-2, almost_full asserted when count ≥ this.
- ALMOST_EMPTY_LEVEL, 1, almost_empty asserted when count ≤ this.

- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- flush  in  1  synchronous discard of all contents; same effect as reset on datapath state.
- s_tdata  in  DATA_WIDTH  write payload.
- s_tvalid  in  1  write request.
- s_tready  out  1  high when count < DEPTH and not in reset/flush.
- m_tdata  out  DATA_WIDTH  head-of-FIFO word, valid while m_tvalid.
- m_tvalid  out  1  head word available.
- m_tready  in  1  consumer accepts head word.
- count  out  ADDR_WIDTH+1  words held (RAM + prefetch stage + in-flight read), 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count ≥ ALMOST_FULL_LEVEL.
- almost_empty  out  1  count ≤ ALMOST_EMPTY_LEVEL.

## Operation
- Push: s_tvalid && s_tready at an edge writes s_tdata to RAM[wr_ptr]; wr_ptr advances, wrapping DEPTH-1 → 0 (not 2^ADDR_WIDTH).
- Pop: m_tvalid && m_tready at an edge consumes the head word.
- count: +1 on push only, −1 on pop only, unchanged on simultaneous push+pop; never exceeds DEPTH or underflows.
- Prefetch stage: two registers (head, skid). A RAM read at rd_ptr issues when RAM holds ≥1 word not yet read and (occupied stage slots + in-flight reads − pop this cycle) < 2; rd_ptr wraps like wr_ptr. Returned data fills head if free/being consumed, else skid; skid moves to head on pop.
- RAM read of an address is never issued in the same cycle it is written; a word pushed at edge N is readable from edge N+1.
- m_tdata and m_tvalid are register outputs; m_tdata stable while m_tvalid && !m_tready.
- flush (or reset): wr_ptr, rd_ptr, count, in-flight read flag, head/skid valid all cleared at that edge; any push/pop presented in that cycle is ignored; s_tready low during flush cycle.
- Flags are pure decodes of registered count; they change on the same edge as count.

## Timing
- Reset/flush values: s_tready 0 while asserted, 1 first cycle after; m_tvalid 0; count 0; empty 1; full 0; almost_empty 1 (for ALMOST_EMPTY_LEVEL ≥ 0); almost_full 0.
- First-word latency: push into empty FIFO at edge N → RAM read at edge N+1 → m_tvalid high after edge N+2.
- Throughput: with m_tready held high and continuous pushes, one pop per clock after initial latency; no bubbles, including across pointer wrap.
- Full: count == DEPTH → s_tready low; a pop at edge N raises s_tready after edge N (combinational from count, no extra cycle). Push+pop while full not possible (s_tready low).
- Empty: m_tvalid low; count is 1 during the 2-cycle fill latency even though m_tvalid is low.
- Backpressure: m_tready low holds head; stage fills to 2, then RAM reads stop; no word lost or duplicated.

## Test plan
- Reset then push 0x01..0x05 on consecutive cycles, m_tready=1 → m_tvalid rises 2 cycles after first push; words 0x01..0x05 popped in order on consecutive cycles; count returns to 0, empty=1.
- DEPTH=5, m_tready=0, push 7 words → 5 accepted, s_tready low after 5th push, full=1, count=5, almost_full=1 from count 3; then one pop → s_tready high next cycle, count=4.
- DEPTH=5, continuous push and pop of counter pattern for 40 cycles → output sequence equals input, no gaps after latency, pointers wrap 4→0 repeatedly, count steady.
- Random s_tvalid/m_tready (50%) for 10,000 cycles, DEPTH=512 → scoreboard match, count == pushes − pops every cycle, m_tdata stable during stalls.
- Fill with 3 words, assert flush with simultaneous s_tvalid and m_tready → next cycle count=0, empty=1, m_tvalid=0; subsequent push of 0xAA emerges as first word.
- Assert reset mid-burst with 10 words held → identical to flush: all outputs at reset values one cycle later, no stale words emitted.
